// File: rtl/regfile_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : regfile_access_ctrl_if
// Brief     : Bundles the core request/response handshake, the register-file
//             side signals and the status outputs of regfile_access_ctrl.
// Revision  : 1.0 - initial release
// ============================================================================
interface regfile_access_ctrl_if;

   // core request channel
   logic        req_valid;
   logic        req_ready;
   logic        req_op;
   logic        req_wide;
   logic [2:0]  req_rs1;
   logic [2:0]  req_rs2;
   logic [2:0]  req_rd;
   logic [15:0] req_wdata;

   // read response channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_rs1_data;
   logic [7:0]  rsp_rs2_data;

   // register-file side
   logic [2:0]  rf_rs1_addr;
   logic [2:0]  rf_rs2_addr;
   logic [2:0]  rf_rd_addr;
   logic [15:0] rf_rd_data;
   logic        rf_r_w;
   logic        rf_input_length;
   logic [7:0]  rf_rs1_data;
   logic [7:0]  rf_rs2_data;

   // status
   logic        err_wide_r7;
   logic [7:0]  rd_count;
   logic [7:0]  wr_count;

   // environment side: core plus register file
   modport master (
      output req_valid, req_op, req_wide, req_rs1, req_rs2, req_rd, req_wdata,
      output rsp_ready, rf_rs1_data, rf_rs2_data,
      input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
      input  rf_rs1_addr, rf_rs2_addr, rf_rd_addr, rf_rd_data, rf_r_w,
      input  rf_input_length, err_wide_r7, rd_count, wr_count
   );

   // controller side
   modport slave (
      input  req_valid, req_op, req_wide, req_rs1, req_rs2, req_rd, req_wdata,
      input  rsp_ready, rf_rs1_data, rf_rs2_data,
      output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data,
      output rf_rs1_addr, rf_rs2_addr, rf_rd_addr, rf_rd_data, rf_r_w,
      output rf_input_length, err_wide_r7, rd_count, wr_count
   );

endinterface
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Brief    : Sequences core read/write requests onto an 8x8-bit register
//            file: timed read capture with response handshake, three-phase
//            write strobe, wide-write-to-r7 rejection and saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl #(
   parameter int READ_WAIT = 1     // read settle cycles, 1..15
) (
   input  wire logic              clk,
   input  wire logic              reset,   // asynchronous, active low
   regfile_access_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RSP      = 3'd2,
      WR_SETUP = 3'd3,
      WR_PULSE = 3'd4,
      WR_HOLD  = 3'd5
   } state_t;

   localparam logic [3:0] c_read_wait = 4'(READ_WAIT);
   localparam logic [7:0] c_cnt_max   = 8'hFF;

   state_t      state_q,           state_d;
   logic [3:0]  wait_cnt_q,        wait_cnt_d;
   logic        req_ready_q,       req_ready_d;
   logic        rsp_valid_q,       rsp_valid_d;
   logic [7:0]  rsp_rs1_data_q,    rsp_rs1_data_d;
   logic [7:0]  rsp_rs2_data_q,    rsp_rs2_data_d;
   logic [2:0]  rf_rs1_addr_q,     rf_rs1_addr_d;
   logic [2:0]  rf_rs2_addr_q,     rf_rs2_addr_d;
   logic [2:0]  rf_rd_addr_q,      rf_rd_addr_d;
   logic [15:0] rf_rd_data_q,      rf_rd_data_d;
   logic        rf_r_w_q,          rf_r_w_d;
   logic        rf_input_length_q, rf_input_length_d;
   logic        err_wide_r7_q,     err_wide_r7_d;
   logic [7:0]  rd_count_q,        rd_count_d;
   logic [7:0]  wr_count_q,        wr_count_d;

   // Next-state and registered-output computation for the access sequencer
   always_comb begin
      state_d           = state_q;
      wait_cnt_d        = wait_cnt_q;
      req_ready_d       = req_ready_q;
      rsp_valid_d       = rsp_valid_q;
      rsp_rs1_data_d    = rsp_rs1_data_q;
      rsp_rs2_data_d    = rsp_rs2_data_q;
      rf_rs1_addr_d     = rf_rs1_addr_q;
      rf_rs2_addr_d     = rf_rs2_addr_q;
      rf_rd_addr_d      = rf_rd_addr_q;
      rf_rd_data_d      = rf_rd_data_q;
      rf_r_w_d          = 1'b1;
      rf_input_length_d = rf_input_length_q;
      err_wide_r7_d     = err_wide_r7_q;
      rd_count_d        = rd_count_q;
      wr_count_d        = wr_count_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               if (!bus.req_op) begin
                  rf_rs1_addr_d = bus.req_rs1;
                  rf_rs2_addr_d = bus.req_rs2;
                  wait_cnt_d    = c_read_wait;
                  state_d       = RD_WAIT;
               end else begin
                  // The rf outputs double as the latched write request
                  rf_rd_addr_d      = bus.req_rd;
                  rf_rd_data_d      = bus.req_wdata;
                  rf_input_length_d = bus.req_wide;
                  state_d           = WR_SETUP;
               end
            end
         end

         RD_WAIT: begin
            // <= 1 also covers a zero load so the wait can never stall
            if (wait_cnt_q <= 4'd1) begin
               rsp_rs1_data_d = bus.rf_rs1_data;
               rsp_rs2_data_d = bus.rf_rs2_data;
               rsp_valid_d    = 1'b1;
               wait_cnt_d     = 4'd0;
               state_d        = RSP;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end

         RSP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               if (rd_count_q != c_cnt_max) begin
                  rd_count_d = rd_count_q + 8'd1;
               end
               state_d = IDLE;
            end
         end

         WR_SETUP: begin
            // r7 has no rd+1 partner, so a wide write there is dropped
            if (rf_input_length_q && (rf_rd_addr_q == 3'd7)) begin
               err_wide_r7_d = 1'b1;
               req_ready_d   = 1'b1;
               state_d       = IDLE;
            end else begin
               rf_r_w_d = 1'b0;
               state_d  = WR_PULSE;
            end
         end

         WR_PULSE: begin
            state_d = WR_HOLD;
         end

         WR_HOLD: begin
            req_ready_d = 1'b1;
            if (wr_count_q != c_cnt_max) begin
               wr_count_d = wr_count_q + 8'd1;
            end
            state_d = IDLE;
         end

         default: begin
            req_ready_d = 1'b1;
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers; reset forces the write strobe inactive at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= IDLE;
         wait_cnt_q        <= 4'd0;
         req_ready_q       <= 1'b1;
         rsp_valid_q       <= 1'b0;
         rsp_rs1_data_q    <= 8'd0;
         rsp_rs2_data_q    <= 8'd0;
         rf_rs1_addr_q     <= 3'd0;
         rf_rs2_addr_q     <= 3'd0;
         rf_rd_addr_q      <= 3'd0;
         rf_rd_data_q      <= 16'd0;
         rf_r_w_q          <= 1'b1;
         rf_input_length_q <= 1'b0;
         err_wide_r7_q     <= 1'b0;
         rd_count_q        <= 8'd0;
         wr_count_q        <= 8'd0;
      end else begin
         state_q           <= state_d;
         wait_cnt_q        <= wait_cnt_d;
         req_ready_q       <= req_ready_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_rs1_data_q    <= rsp_rs1_data_d;
         rsp_rs2_data_q    <= rsp_rs2_data_d;
         rf_rs1_addr_q     <= rf_rs1_addr_d;
         rf_rs2_addr_q     <= rf_rs2_addr_d;
         rf_rd_addr_q      <= rf_rd_addr_d;
         rf_rd_data_q      <= rf_rd_data_d;
         rf_r_w_q          <= rf_r_w_d;
         rf_input_length_q <= rf_input_length_d;
         err_wide_r7_q     <= err_wide_r7_d;
         rd_count_q        <= rd_count_d;
         wr_count_q        <= wr_count_d;
      end
   end

   assign bus.req_ready       = req_ready_q;
   assign bus.rsp_valid       = rsp_valid_q;
   assign bus.rsp_rs1_data    = rsp_rs1_data_q;
   assign bus.rsp_rs2_data    = rsp_rs2_data_q;
   assign bus.rf_rs1_addr     = rf_rs1_addr_q;
   assign bus.rf_rs2_addr     = rf_rs2_addr_q;
   assign bus.rf_rd_addr      = rf_rd_addr_q;
   assign bus.rf_rd_data      = rf_rd_data_q;
   assign bus.rf_r_w          = rf_r_w_q;
   assign bus.rf_input_length = rf_input_length_q;
   assign bus.err_wide_r7     = err_wide_r7_q;
   assign bus.rd_count        = rd_count_q;
   assign bus.wr_count        = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_ctrl
// Brief    : Directed self-checking bench for regfile_access_ctrl, one
//            instance with READ_WAIT=1 and one with READ_WAIT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_access_ctrl;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   regfile_access_ctrl_if ifa ();
   regfile_access_ctrl_if ifb ();

   regfile_access_ctrl #(.READ_WAIT(1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   regfile_access_ctrl #(.READ_WAIT(3)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // absolute watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one complete non-rejected write, checked at E..E+3
   task automatic do_write(input logic [2:0] rd, input logic wide, input logic [15:0] data,
                           input logic [7:0] exp_wr);
      ifa.req_valid = 1'b1;
      ifa.req_op    = 1'b1;
      ifa.req_wide  = wide;
      ifa.req_rd    = rd;
      ifa.req_wdata = data;
      tick;                                   // E
      ifa.req_valid = 1'b0;
      check("wr_E_rw",    16'(ifa.rf_r_w), 16'd1);
      check("wr_E_ready", 16'(ifa.req_ready), 16'd0);
      check("wr_E_addr",  16'(ifa.rf_rd_addr), 16'(rd));
      check("wr_E_data",  ifa.rf_rd_data, data);
      check("wr_E_len",   16'(ifa.rf_input_length), 16'(wide));
      tick;                                   // E+1
      check("wr_E1_rw",   16'(ifa.rf_r_w), 16'd0);
      check("wr_E1_addr", 16'(ifa.rf_rd_addr), 16'(rd));
      check("wr_E1_data", ifa.rf_rd_data, data);
      tick;                                   // E+2
      check("wr_E2_rw",   16'(ifa.rf_r_w), 16'd1);
      check("wr_E2_addr", 16'(ifa.rf_rd_addr), 16'(rd));
      check("wr_E2_data", ifa.rf_rd_data, data);
      check("wr_E2_ready", 16'(ifa.req_ready), 16'd0);
      tick;                                   // E+3
      check("wr_E3_ready", 16'(ifa.req_ready), 16'd1);
      check("wr_E3_cnt",   16'(ifa.wr_count), 16'(exp_wr));
      check("wr_E3_rsp",   16'(ifa.rsp_valid), 16'd0);
      check("wr_E3_rw",    16'(ifa.rf_r_w), 16'd1);
      check("wr_E3_data",  ifa.rf_rd_data, data);
   endtask

   initial begin
      int resp_seen;
      n_checks = 0;
      n_fail   = 0;

      reset = 1'b0;
      ifa.req_valid = 1'b0; ifa.req_op = 1'b0; ifa.req_wide = 1'b0;
      ifa.req_rs1 = 3'd0; ifa.req_rs2 = 3'd0; ifa.req_rd = 3'd0; ifa.req_wdata = 16'd0;
      ifa.rsp_ready = 1'b0; ifa.rf_rs1_data = 8'd0; ifa.rf_rs2_data = 8'd0;
      ifb.req_valid = 1'b0; ifb.req_op = 1'b0; ifb.req_wide = 1'b0;
      ifb.req_rs1 = 3'd0; ifb.req_rs2 = 3'd0; ifb.req_rd = 3'd0; ifb.req_wdata = 16'd0;
      ifb.rsp_ready = 1'b0; ifb.rf_rs1_data = 8'd0; ifb.rf_rs2_data = 8'd0;

      tick;
      tick;
      // ---- reset values
      check("rst_ready", 16'(ifa.req_ready), 16'd1);
      check("rst_rsp",   16'(ifa.rsp_valid), 16'd0);
      check("rst_rw",    16'(ifa.rf_r_w), 16'd1);
      check("rst_len",   16'(ifa.rf_input_length), 16'd0);
      check("rst_err",   16'(ifa.err_wide_r7), 16'd0);
      check("rst_rdc",   16'(ifa.rd_count), 16'd0);
      check("rst_wrc",   16'(ifa.wr_count), 16'd0);
      check("rst_data",  ifa.rf_rd_data, 16'd0);
      check("rst_rsp1",  16'(ifa.rsp_rs1_data), 16'd0);
      reset = 1'b1;
      tick;

      // ---- read rs1=2 rs2=5, rsp_ready low for 3 cycles
      ifa.req_valid = 1'b1; ifa.req_op = 1'b0; ifa.req_rs1 = 3'd2; ifa.req_rs2 = 3'd5;
      ifa.rf_rs1_data = 8'h3C; ifa.rf_rs2_data = 8'hA5;
      tick;                                   // E
      ifa.req_valid = 1'b0;
      check("rd_E_ready", 16'(ifa.req_ready), 16'd0);
      check("rd_E_a1",    16'(ifa.rf_rs1_addr), 16'd2);
      check("rd_E_a2",    16'(ifa.rf_rs2_addr), 16'd5);
      check("rd_E_rsp",   16'(ifa.rsp_valid), 16'd0);
      tick;                                   // E+1
      check("rd_E1_rsp",  16'(ifa.rsp_valid), 16'd1);
      check("rd_E1_d1",   16'(ifa.rsp_rs1_data), 16'h3C);
      check("rd_E1_d2",   16'(ifa.rsp_rs2_data), 16'hA5);
      ifa.rf_rs1_data = 8'h00; ifa.rf_rs2_data = 8'h00;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("rd_hold_rsp", 16'(ifa.rsp_valid), 16'd1);
         check("rd_hold_d1",  16'(ifa.rsp_rs1_data), 16'h3C);
         check("rd_hold_d2",  16'(ifa.rsp_rs2_data), 16'hA5);
      end
      ifa.rsp_ready = 1'b1;
      tick;
      ifa.rsp_ready = 1'b0;
      check("rd_done_rsp",   16'(ifa.rsp_valid), 16'd0);
      check("rd_done_cnt",   16'(ifa.rd_count), 16'd1);
      check("rd_done_ready", 16'(ifa.req_ready), 16'd1);
      check("rd_done_wrc",   16'(ifa.wr_count), 16'd0);

      // ---- narrow write rd=3
      do_write(3'd3, 1'b0, 16'h00F0, 8'd1);

      // ---- wide write to r7 is rejected
      ifa.req_valid = 1'b1; ifa.req_op = 1'b1; ifa.req_wide = 1'b1;
      ifa.req_rd = 3'd7; ifa.req_wdata = 16'h1234;
      tick;                                   // E
      ifa.req_valid = 1'b0;
      check("r7_E_rw",  16'(ifa.rf_r_w), 16'd1);
      check("r7_E_err", 16'(ifa.err_wide_r7), 16'd0);
      tick;                                   // E+1
      check("r7_E1_rw",    16'(ifa.rf_r_w), 16'd1);
      check("r7_E1_err",   16'(ifa.err_wide_r7), 16'd1);
      check("r7_E1_ready", 16'(ifa.req_ready), 16'd1);
      check("r7_E1_wrc",   16'(ifa.wr_count), 16'd1);
      tick;
      check("r7_E2_rw",  16'(ifa.rf_r_w), 16'd1);
      check("r7_E2_err", 16'(ifa.err_wide_r7), 16'd1);

      // ---- wide write rd=6 pulses normally, narrow write to r7 legal
      do_write(3'd6, 1'b1, 16'h1234, 8'd2);
      check("err_sticky", 16'(ifa.err_wide_r7), 16'd1);
      do_write(3'd7, 1'b0, 16'h0055, 8'd3);
      check("err_sticky2", 16'(ifa.err_wide_r7), 16'd1);

      // ---- reset asserted during WR_PULSE
      ifa.req_valid = 1'b1; ifa.req_op = 1'b1; ifa.req_wide = 1'b0;
      ifa.req_rd = 3'd2; ifa.req_wdata = 16'hABCD;
      tick;                                   // E
      ifa.req_valid = 1'b0;
      tick;                                   // E+1, strobe low
      check("rstw_pulse", 16'(ifa.rf_r_w), 16'd0);
      #2;
      reset = 1'b0;
      #1;                                     // still well before the next edge
      check("rstw_rw",    16'(ifa.rf_r_w), 16'd1);
      check("rstw_addr",  16'(ifa.rf_rd_addr), 16'd0);
      check("rstw_data",  ifa.rf_rd_data, 16'd0);
      check("rstw_wrc",   16'(ifa.wr_count), 16'd0);
      check("rstw_rdc",   16'(ifa.rd_count), 16'd0);
      check("rstw_err",   16'(ifa.err_wide_r7), 16'd0);
      check("rstw_ready", 16'(ifa.req_ready), 16'd1);
      check("rstw_a1",    16'(ifa.rf_rs1_addr), 16'd0);
      #2;
      reset = 1'b1;
      tick;
      tick;
      check("rstw_after_wrc", 16'(ifa.wr_count), 16'd0);
      check("rstw_after_rw",  16'(ifa.rf_r_w), 16'd1);

      // ---- 256 back-to-back reads, rsp_ready tied high
      ifa.rf_rs1_data = 8'h11; ifa.rf_rs2_data = 8'h22;
      ifa.req_op = 1'b0; ifa.req_rs1 = 3'd1; ifa.req_rs2 = 3'd4;
      ifa.rsp_ready = 1'b1;
      ifa.req_valid = 1'b1;
      resp_seen = 0;
      for (int cyc = 0; cyc < 1000 && resp_seen < 256; cyc++) begin
         tick;
         if (ifa.rsp_valid) begin
            resp_seen++;
            if (resp_seen == 256) ifa.req_valid = 1'b0;
         end
      end
      tick;
      tick;
      ifa.rsp_ready = 1'b0;
      check("b2b_resp", 16'(resp_seen), 16'd256);
      check("b2b_rdc",  16'(ifa.rd_count), 16'd255);
      check("b2b_d1",   16'(ifa.rsp_rs1_data), 16'h11);
      check("b2b_ready", 16'(ifa.req_ready), 16'd1);

      // ---- READ_WAIT=3 instance
      ifb.req_valid = 1'b1; ifb.req_op = 1'b0; ifb.req_rs1 = 3'd4; ifb.req_rs2 = 3'd1;
      ifb.rf_rs1_data = 8'h5A; ifb.rf_rs2_data = 8'hC3;
      tick;                                   // E
      ifb.req_valid = 1'b0;
      check("rw3_E_rsp", 16'(ifb.rsp_valid), 16'd0);
      check("rw3_E_a1",  16'(ifb.rf_rs1_addr), 16'd4);
      check("rw3_E_a2",  16'(ifb.rf_rs2_addr), 16'd1);
      for (int k = 1; k <= 2; k++) begin
         tick;                                // E+1, E+2
         check("rw3_wait_rsp", 16'(ifb.rsp_valid), 16'd0);
         check("rw3_wait_a1",  16'(ifb.rf_rs1_addr), 16'd4);
         check("rw3_wait_a2",  16'(ifb.rf_rs2_addr), 16'd1);
      end
      tick;                                   // E+3
      check("rw3_E3_rsp", 16'(ifb.rsp_valid), 16'd1);
      check("rw3_E3_d1",  16'(ifb.rsp_rs1_data), 16'h5A);
      check("rw3_E3_d2",  16'(ifb.rsp_rs2_data), 16'hC3);
      check("rw3_E3_a1",  16'(ifb.rf_rs1_addr), 16'd4);
      ifb.rsp_ready = 1'b1;
      tick;
      ifb.rsp_ready = 1'b0;
      check("rw3_done_rsp", 16'(ifb.rsp_valid), 16'd0);
      check("rw3_done_rdc", 16'(ifb.rd_count), 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_access_ctrl.md
REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

Interface
REQ-001 The block SHALL have parameter READ_WAIT, default 1: register-file read settle cycles, legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: core request valid.
REQ-005 The block SHALL have port req_ready, output, 1 bit: block accepts a request; high only in IDLE.
REQ-006 The block SHALL have port req_op, input, 1 bit: 0 = read, 1 = write.
REQ-007 The block SHALL have port req_wide, input, 1 bit: on a write, 1 = 16-bit write to rd/rd+1, 0 = 8-bit write.
REQ-008 The block SHALL have ports req_rs1, req_rs2, req_rd, input, 3 bits each: source and destination register indices.
REQ-009 The block SHALL have port req_wdata, input, 16 bits: write data; [15:8] goes to rd and [7:0] to rd+1 when wide.
REQ-010 The block SHALL have ports rsp_valid (output, 1 bit) and rsp_ready (input, 1 bit): read-response handshake.
REQ-011 The block SHALL have ports rsp_rs1_data and rsp_rs2_data, output, 8 bits each: captured read data.
REQ-012 The block SHALL have ports rf_rs1_addr, rf_rs2_addr and rf_rd_addr, output, 3 bits each, driven to the register file.
REQ-013 The block SHALL have port rf_rd_data, output, 16 bits, driven to the register file.
REQ-014 The block SHALL have ports rf_r_w (output, 1 bit; 1 = read, 0 = write) and rf_input_length (output, 1 bit; 1 = 16-bit).
REQ-015 The block SHALL have ports rf_rs1_data and rf_rs2_data, input, 8 bits each, returned from the register file.
REQ-016 The block SHALL have port err_wide_r7, output, 1 bit: sticky flag for a rejected wide write to r7.
REQ-017 The block SHALL have ports rd_count and wr_count, output, 8 bits each: saturating counts of completed reads and writes.

Function
REQ-018 All outputs SHALL be registered; rf_r_w SHALL be 0 only in state WR_PULSE.
REQ-019 FSM states SHALL be IDLE, RD_WAIT, RSP, WR_SETUP, WR_PULSE and WR_HOLD.
REQ-020 Acceptance occurs at edge E when req_valid and req_ready are both 1; at E the block SHALL latch all req_* fields.
REQ-021 An accepted read SHALL drive rf_rs1_addr/rf_rs2_addr and enter RD_WAIT at E.
REQ-022 The block SHALL remain in RD_WAIT for READ_WAIT cycles, counted by a 4-bit down-counter.
REQ-023 At edge E+READ_WAIT the block SHALL capture rf_rs*_data into rsp_rs*_data, set rsp_valid, and enter RSP.
REQ-024 In RSP, rsp_valid and rsp data SHALL hold stable until the edge with rsp_ready=1.
REQ-025 At that rsp_ready edge the block SHALL clear rsp_valid, increment rd_count, and return to IDLE; a new request accepted at the next edge is legal.
REQ-026 An accepted write SHALL enter WR_SETUP at E, driving rf_rd_addr, rf_rd_data and rf_input_length with rf_r_w=1.
REQ-027 The write sequence SHALL be WR_PULSE (rf_r_w=0) during E+1..E+2, WR_HOLD during E+2..E+3 (rf_r_w=1, address and data unchanged), then IDLE at E+3 with wr_count incremented.
REQ-028 Writes SHALL produce no rsp_valid.
REQ-029 A wide write with req_rd=7 SHALL NOT pulse rf_r_w; the block SHALL set err_wide_r7 and return to IDLE at E+1 with wr_count unchanged.
REQ-030 err_wide_r7 SHALL be cleared only by reset.
REQ-031 A narrow write to r7 SHALL be legal.
REQ-032 rd_count and wr_count SHALL saturate at 255 and never wrap.
REQ-033 req_valid while req_ready=0 SHALL be ignored with no queuing; the requester holds the request.
REQ-034 rf_* address and data outputs SHALL keep their last values in IDLE; rf_r_w SHALL stay 1.

Reset
REQ-035 On reset low, the block SHALL immediately (asynchronously) enter IDLE, including mid-RD_WAIT, mid-RSP and mid-WR_PULSE.
REQ-036 Reset values SHALL be: req_ready=1, rsp_valid=0, rsp data=0, rf addresses=0, rf_rd_data=0, rf_r_w=1, rf_input_length=0, err_wide_r7=0, counters=0.
REQ-037 A write interrupted by reset SHALL force rf_r_w=1 in the same instant and SHALL NOT be counted.

Verification
REQ-038 Read rs1=2, rs2=5, READ_WAIT=1, register file returns 8'h3C/8'hA5 -> rsp_valid at E+1 with 3C/A5; with rsp_ready held low 3 cycles, data stays stable; rd_count becomes 1.
REQ-039 Narrow write rd=3, wdata=16'h00F0 -> rf_r_w=0 for exactly one cycle (E+1..E+2), rf_input_length=0, addr=3, data=00F0 stable E..E+3; wr_count=1; req_ready high at E+3.
REQ-040 Wide write rd=7, wdata=16'h1234 -> rf_r_w never 0, err_wide_r7=1 at E+1 and persisting; a wide write to rd=6 afterwards pulses normally with rf_input_length=1.
REQ-041 Reset asserted during WR_PULSE -> rf_r_w=1 and all outputs at reset values immediately, before the next edge; wr_count=0.
REQ-042 256 back-to-back reads with rsp_ready tied high -> rd_count=255, no wrap, no missed responses.
REQ-043 READ_WAIT=3 read -> rsp_valid first high at E+3; rf_rs* addresses stable over E..E+3.
